lif_neuron_accum: RTL and testbench

//  Downstream consumer of the held spike vector from the spike delay stage (spike_o/next_stage).

---
 rtl/snn_pkg.sv | 44 ++++
 rtl/spike_weight_sum.sv | 27 ++
 rtl/lif_neuron_accum.sv | 186 ++++++++++++++++++
 tb/tb_lif_neuron_accum.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared sizing, FSM state type and membrane saturation helper for the LIF neuron datapath.
package snn_pkg;

    function automatic int unsigned beats_f(input int unsigned n, input int unsigned lanes);
        return (n + lanes - 1) / lanes;
    endfunction

    function automatic int unsigned acc_w_f(input int unsigned w, input int unsigned n);
        return w + $clog2(n) + 1;
    endfunction

    localparam int unsigned NUM_WEIGHT    = 961;
    localparam int unsigned LANES         = 32;
    localparam int unsigned W_WIDTH       = 8;
    localparam int unsigned V_WIDTH       = 16;
    localparam int unsigned LEAK_SHIFT    = 4;
    localparam int unsigned REFRACT_STEPS = 2;

    localparam int unsigned BEATS  = beats_f(NUM_WEIGHT, LANES);
    localparam int unsigned ACC_W  = acc_w_f(W_WIDTH, NUM_WEIGHT);
    localparam int unsigned SUM_W  = ACC_W + 2;
    localparam int unsigned ADDR_W = $clog2(BEATS);
    localparam int unsigned PAD_W  = BEATS * LANES;
    localparam int unsigned REFR_W = $clog2(REFRACT_STEPS + 1);

    localparam logic signed [V_WIDTH-1:0] THRESHOLD = V_WIDTH'(1000);
    localparam int V_MAX = (1 << (V_WIDTH - 1)) - 1;
    localparam int V_MIN = -V_MAX - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FLUSH,
        ST_UPDATE
    } lif_state_e;

    // Clamp a wide update result into the membrane potential range.
    function automatic logic signed [V_WIDTH-1:0] sat_v(input logic signed [SUM_W-1:0] x);
        if (x > SUM_W'(V_MAX)) return V_WIDTH'(V_MAX);
        if (x < SUM_W'(V_MIN)) return V_WIDTH'(V_MIN);
        return V_WIDTH'(x);
    endfunction

endpackage

// File: rtl/spike_weight_sum.sv
// Combinational masked signed sum of one beat of synaptic weights.
module spike_weight_sum
    import snn_pkg::*;
(
    input  logic [LANES*W_WIDTH-1:0] weights_i,
    input  logic [LANES-1:0]         spike_mask_i,
    input  logic [LANES-1:0]         valid_mask_i,
    output logic signed [ACC_W-1:0]  sum_c_o
);

    logic signed [W_WIDTH-1:0] lane_w;
    logic signed [ACC_W-1:0]   sum;

    always_comb begin
        sum    = '0;
        lane_w = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_w = weights_i[l*W_WIDTH +: W_WIDTH];
            if (spike_mask_i[l] && valid_mask_i[l]) begin
                sum = sum + ACC_W'(lane_w);
            end
        end
    end

    assign sum_c_o = sum;

endmodule

// File: rtl/lif_neuron_accum.sv
// Leaky integrate-and-fire neuron: streams weights per beat, integrates, leaks and fires.
// Optional refractory period enabled by defining LIF_REFRACTORY_EN.
module lif_neuron_accum
    import snn_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_WEIGHT-1:0]      spike_i,
    input  logic                       start_i,
    output logic                       weight_rd_o,
    output logic [ADDR_W-1:0]          weight_addr_o,
    input  logic [LANES*W_WIDTH-1:0]   weight_data_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       spike_o,
    output logic signed [V_WIDTH-1:0]  vmem_o
);

    lif_state_e                state_q, state_d;
    logic [PAD_W-1:0]          spikes_q, spikes_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [ADDR_W-1:0]         dbeat_q, dbeat_d;
    logic                      rd_q, rd_d;
    logic                      dv_q, dv_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [V_WIDTH-1:0] vmem_q, vmem_d;
    logic                      spike_q, spike_d;
    logic                      done_q, done_d;
    logic                      busy_q, busy_d;
`ifdef LIF_REFRACTORY_EN
    logic [REFR_W-1:0]         refr_q, refr_d;
`endif

    logic [LANES-1:0]          lane_spk_c;
    logic [LANES-1:0]          lane_vld_c;
    logic signed [ACC_W-1:0]   beat_sum_c;
    logic signed [SUM_W-1:0]   upd_sum_c;
    logic signed [V_WIDTH-1:0] v_new_c;

    // Lane masks for the beat whose read data is arriving this cycle.
    always_comb begin
        lane_spk_c = spikes_q[32'(dbeat_q) * LANES +: LANES];
        lane_vld_c = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_vld_c[l] = (32'(dbeat_q) * LANES + l) < NUM_WEIGHT;
        end
    end

    spike_weight_sum u_sum (
        .weights_i    (weight_data_i),
        .spike_mask_i (lane_spk_c),
        .valid_mask_i (lane_vld_c),
        .sum_c_o      (beat_sum_c)
    );

    assign upd_sum_c = SUM_W'(vmem_q) - SUM_W'(vmem_q >>> LEAK_SHIFT) + SUM_W'(acc_q);
    assign v_new_c   = sat_v(upd_sum_c);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            spikes_q <= '0;
            addr_q   <= '0;
            dbeat_q  <= '0;
            rd_q     <= 1'b0;
            dv_q     <= 1'b0;
            acc_q    <= '0;
            vmem_q   <= '0;
            spike_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef LIF_REFRACTORY_EN
            refr_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            spikes_q <= spikes_d;
            addr_q   <= addr_d;
            dbeat_q  <= dbeat_d;
            rd_q     <= rd_d;
            dv_q     <= dv_d;
            acc_q    <= acc_d;
            vmem_q   <= vmem_d;
            spike_q  <= spike_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef LIF_REFRACTORY_EN
            refr_q   <= refr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        spikes_d = spikes_q;
        addr_d   = addr_q;
        rd_d     = rd_q;
        acc_d    = acc_q;
        vmem_d   = vmem_q;
        spike_d  = spike_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dv_d     = rd_q;
        dbeat_d  = addr_q;
`ifdef LIF_REFRACTORY_EN
        refr_d   = refr_q;
`endif

        // Read data lags the address by one cycle, so accumulate the previous beat.
        if (dv_q) begin
            acc_d = acc_q + beat_sum_c;
        end

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start_i && !busy_q) begin
                    spikes_d = PAD_W'(spike_i);
                    acc_d    = '0;
                    addr_d   = '0;
                    busy_d   = 1'b1;
`ifdef LIF_REFRACTORY_EN
                    if (refr_q != '0) begin
                        state_d = ST_UPDATE;
                    end else begin
                        state_d = ST_ACCUM;
                        rd_d    = 1'b1;
                    end
`else
                    state_d = ST_ACCUM;
                    rd_d    = 1'b1;
`endif
                end
            end
            ST_ACCUM: begin
                if (addr_q == ADDR_W'(BEATS - 1)) begin
                    rd_d    = 1'b0;
                    addr_d  = '0;
                    state_d = ST_FLUSH;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_FLUSH: begin
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
`ifdef LIF_REFRACTORY_EN
                if (refr_q != '0) begin
                    vmem_d  = '0;
                    spike_d = 1'b0;
                    refr_d  = refr_q - REFR_W'(1);
                end else if (v_new_c >= THRESHOLD) begin
                    vmem_d  = '0;
                    spike_d = 1'b1;
                    refr_d  = REFR_W'(REFRACT_STEPS);
                end else begin
                    vmem_d  = v_new_c;
                    spike_d = 1'b0;
                end
`else
                if (v_new_c >= THRESHOLD) begin
                    vmem_d  = '0;
                    spike_d = 1'b1;
                end else begin
                    vmem_d  = v_new_c;
                    spike_d = 1'b0;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign weight_rd_o   = rd_q;
    assign weight_addr_o = addr_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign spike_o       = spike_q;
    assign vmem_o        = vmem_q;

endmodule

// File: tb/tb_lif_neuron_accum.sv
// Randomized self-checking bench for lif_neuron_accum against an arithmetic neuron model.
module tb_lif_neuron_accum;
    import snn_pkg::*;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic [NUM_WEIGHT-1:0]     spike_i;
    logic                      start_i;
    logic                      weight_rd_o;
    logic [ADDR_W-1:0]         weight_addr_o;
    logic [LANES*W_WIDTH-1:0]  weight_data_i;
    logic                      busy_o;
    logic                      done_o;
    logic                      spike_o;
    logic signed [V_WIDTH-1:0] vmem_o;

    int n_chk  = 0;
    int n_pass = 0;
    int vmem_m = 0;
    int refr_m = 0;

    logic signed [W_WIDTH-1:0] wt [PAD_W];
    logic [NUM_WEIGHT-1:0]     ones_v;
    logic [NUM_WEIGHT-1:0]     sp_v;

    lif_neuron_accum dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .spike_i       (spike_i),
        .start_i       (start_i),
        .weight_rd_o   (weight_rd_o),
        .weight_addr_o (weight_addr_o),
        .weight_data_i (weight_data_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .spike_o       (spike_o),
        .vmem_o        (vmem_o)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous-read weight RAM.
    always @(posedge clk_i) begin
        if (weight_rd_o) begin
            for (int l = 0; l < LANES; l++) begin
                weight_data_i[l*W_WIDTH +: W_WIDTH] <= wt[32'(weight_addr_o) * LANES + 32'(l)];
            end
        end
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // One timestep of the neuron computed directly from its definition.
    function automatic void model_step(input logic [NUM_WEIGHT-1:0] sp,
                                       output int ev, output int es,
                                       output int erd, output int elat);
        int acc;
        int v;
`ifdef LIF_REFRACTORY_EN
        if (refr_m > 0) begin
            refr_m--;
            vmem_m = 0;
            ev = 0; es = 0; erd = 0; elat = 2;
            return;
        end
`endif
        acc = 0;
        for (int i = 0; i < NUM_WEIGHT; i++) if (sp[i]) acc += int'(wt[i]);
        v = vmem_m - (vmem_m >>> LEAK_SHIFT) + acc;
        if (v > V_MAX) v = V_MAX;
        if (v < V_MIN) v = V_MIN;
        if (v >= 1000) begin
            es = 1; vmem_m = 0; refr_m = REFRACT_STEPS;
        end else begin
            es = 0; vmem_m = v;
        end
        ev = vmem_m; erd = BEATS; elat = BEATS + 3;
    endfunction

    task automatic run_step(input logic [NUM_WEIGHT-1:0] sp, input bit repulse, input string tag);
        int ev, es, erd, elat;
        int c, lat, dones, rdc, addr_err, gv, gs;
        model_step(sp, ev, es, erd, elat);
        @(negedge clk_i);
        spike_i = sp;
        start_i = 1'b1;
        c = 0; lat = 0; dones = 0; rdc = 0; addr_err = 0; gv = 0; gs = 0;
        while (c < 80 && (lat == 0 || c < lat + 2)) begin
            @(negedge clk_i);
            c++;
            start_i = repulse && (c == 5 || c == BEATS + 3);
            if (weight_rd_o) begin
                if (32'(weight_addr_o) != rdc) addr_err++;
                rdc++;
            end
            if (done_o) begin
                dones++;
                if (lat == 0) begin
                    lat = c; gv = int'(vmem_o); gs = int'(spike_o);
                end
            end
        end
        start_i = 1'b0;
        check_val({tag, "_latency"}, lat, elat);
        check_val({tag, "_vmem"}, gv, ev);
        check_val({tag, "_spike"}, gs, es);
        check_val({tag, "_done_count"}, dones, 1);
        check_val({tag, "_rd_cycles"}, rdc, erd);
        check_val({tag, "_addr_order"}, addr_err, 0);
        check_val({tag, "_busy_after"}, busy_o, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        vmem_m = 0;
        refr_m = 0;
    endtask

    initial begin
        ones_v  = '1;
        rst_i   = 1'b1;
        start_i = 1'b0;
        spike_i = '0;
        for (int i = 0; i < PAD_W; i++) wt[i] = '0;
        repeat (3) @(negedge clk_i);
        check_val("rst_vmem", vmem_o, 0);
        check_val("rst_spike", spike_o, 0);
        check_val("rst_done", done_o, 0);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_rd", weight_rd_o, 0);
        check_val("rst_addr", weight_addr_o, 0);
        rst_i = 1'b0;

        // All weights +1, all spikes: integrate, fire, (refractory), integrate again.
        for (int i = 0; i < PAD_W; i++) wt[i] = 8'sd1;
        for (int s = 0; s < 5; s++) run_step(ones_v, 1'b0, $sformatf("t1_s%0d", s + 1));

        // Only the last synapse active; padding lanes carry large weights that must be masked.
        apply_reset();
        for (int i = 0; i < PAD_W; i++) wt[i] = (i >= NUM_WEIGHT) ? 8'sd127 : 8'sd0;
        wt[NUM_WEIGHT-1] = 8'sd5;
        sp_v = '0;
        sp_v[NUM_WEIGHT-1] = 1'b1;
        run_step(sp_v, 1'b0, "t2_mask");
        check_val("t2_vmem_abs", vmem_o, 5);

        // Negative saturation then leak toward zero.
        apply_reset();
        for (int i = 0; i < PAD_W; i++) wt[i] = -8'sd128;
        run_step(ones_v, 1'b0, "t3_sat");
        check_val("t3_sat_abs", vmem_o, -32768);
        run_step('0, 1'b0, "t3_leak");
        check_val("t3_leak_abs", vmem_o, -30720);

        // Asynchronous reset while accumulating.
        @(negedge clk_i);
        spike_i = ones_v;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        check_val("t5_in_accum", weight_rd_o, 1);
        rst_i = 1'b1;
        #1;
        check_val("t5_busy", busy_o, 0);
        check_val("t5_rd", weight_rd_o, 0);
        check_val("t5_vmem", vmem_o, 0);
        check_val("t5_done", done_o, 0);
        @(negedge clk_i);
        rst_i  = 1'b0;
        vmem_m = 0;
        refr_m = 0;
        run_step(ones_v, 1'b0, "t5_after");

        // Extra start pulses while busy and during the done cycle are ignored.
        run_step(ones_v, 1'b1, "t4_repulse");

        // Randomized weights and spike patterns.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < PAD_W; i++) begin
                if (r % 2 == 0) wt[i] = W_WIDTH'($urandom_range(0, 60) - 20);
                else            wt[i] = W_WIDTH'($urandom_range(0, 255));
            end
            for (int i = 0; i < NUM_WEIGHT; i++) sp_v[i] = 1'($urandom_range(0, 1));
            run_step(sp_v, 1'b0, $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
